// File: rtl/wb_i2c_target_if.sv
// Wishbone slave port bundle for wb_i2c_target.
// Latency: none, wires only.
// Backpressure: none, the slave acknowledges every strobe one cycle later.
interface wb_i2c_target_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_i2c_target.sv
// I2C target exposing an 8-byte register bank, shared with Wishbone; I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample input filter.
// Latency: Wishbone ack 1 cycle; I2C inputs 3 cycles (6 with filter), sda updates 1 cycle after a detected scl fall.
// Backpressure: none; scl is never stretched and every Wishbone strobe is acked.
module wb_i2c_target #(
    parameter logic [6:0]  I2C_ADDR  = 7'h42,
    parameter int unsigned clk_freq  = 50000000
) (
    input  logic            clk,
    input  logic            reset,
    wb_i2c_target_if.slave  wb,
    input  logic            scl,
    inout  wire             sda,
    output logic            intr
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    localparam int unsigned unused_clk_freq = clk_freq;

    state_t      state;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_f, sda_f, scl_q, sda_q;
    logic [7:0]  bank [8];
    logic [7:0]  shreg;
    logic [3:0]  bit_cnt;
    logic [2:0]  ptr;
    logic        rw, wrote, sent, ack_seen, sda_low;
    logic        addressed, wr_done, rd_done, nack_end;
    logic        enable, irq_en;
    logic [31:0] rd_mux;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;

    // Output follows only once three consecutive samples agree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            if ({scl_hist, scl_sync[1]} == 3'b000)      scl_f <= 1'b0;
            else if ({scl_hist, scl_sync[1]} == 3'b111) scl_f <= 1'b1;
            if ({sda_hist, sda_sync[1]} == 3'b000)      sda_f <= 1'b0;
            else if ({sda_hist, sda_sync[1]} == 3'b111) sda_f <= 1'b1;
        end
    end
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    wire       scl_rise  = scl_f & ~scl_q;
    wire       scl_fall  = ~scl_f & scl_q;
    wire       start_det = scl_f & scl_q & sda_q & ~sda_f;
    wire       stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    wire [7:0] rx_byte   = {shreg[6:0], sda_f};
    wire       wb_req    = wb.wb_stb_i & wb.wb_cyc_i & ~wb.wb_ack_o;
    wire       wb_wr     = wb.wb_stb_i & wb.wb_cyc_i & wb.wb_ack_o & wb.wb_we_i & wb.wb_sel_i[0];

    always_comb begin
        rd_mux = '0;
        case (wb.wb_adr_i[5:2])
            4'd8:    rd_mux = {28'd0, nack_end, rd_done, wr_done, addressed};
            4'd9:    rd_mux = {30'd0, irq_en, enable};
            default: if (!wb.wb_adr_i[5]) rd_mux = {24'd0, bank[wb.wb_adr_i[4:2]]};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wb.wb_ack_o  <= 1'b0;
            wb.wb_dat_o  <= '0;
            for (int i = 0; i < 8; i++) bank[i] <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            wrote     <= 1'b0;
            sent      <= 1'b0;
            ack_seen  <= 1'b0;
            sda_low   <= 1'b0;
            addressed <= 1'b0;
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
            nack_end  <= 1'b0;
            enable    <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            wb.wb_ack_o <= wb_req;
            wb.wb_dat_o <= wb_req ? rd_mux : 32'd0;

            // Wishbone writes first so that I2C updates below override them.
            if (wb_wr) begin
                case (wb.wb_adr_i[5:2])
                    4'd8: begin
                        wr_done  <= wr_done  & ~wb.wb_dat_i[1];
                        rd_done  <= rd_done  & ~wb.wb_dat_i[2];
                        nack_end <= nack_end & ~wb.wb_dat_i[3];
                    end
                    4'd9: begin
                        enable <= wb.wb_dat_i[0];
                        irq_en <= wb.wb_dat_i[1];
                    end
                    default: if (!wb.wb_adr_i[5]) bank[wb.wb_adr_i[4:2]] <= wb.wb_dat_i[7:0];
                endcase
            end

            if (stop_det) begin
                if (wrote) wr_done <= 1'b1;
                if (sent)  rd_done <= 1'b1;
                wrote     <= 1'b0;
                sent      <= 1'b0;
                addressed <= 1'b0;
                sda_low   <= 1'b0;
                ack_seen  <= 1'b0;
                state     <= IDLE;
            end else if (start_det && (state != IDLE || enable)) begin
                sda_low  <= 1'b0;
                ack_seen <= 1'b0;
                bit_cnt  <= '0;
                state    <= ADDR;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (rx_byte[7:1] == I2C_ADDR) begin
                                addressed <= 1'b1;
                                rw        <= rx_byte[0];
                                state     <= ADDR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    // sda_low doubles as the phase flag: first fall drives ACK, second ends the slot.
                    ADDR_ACK: if (scl_fall) begin
                        bit_cnt <= '0;
                        if (!sda_low) begin
                            sda_low <= 1'b1;
                        end else if (rw) begin
                            sda_low <= ~bank[ptr][7];
                            shreg   <= {bank[ptr][6:0], 1'b0};
                            state   <= RDATA;
                        end else begin
                            sda_low <= 1'b0;
                            state   <= PTR;
                        end
                    end
                    PTR: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            ptr   <= rx_byte[2:0];
                            state <= PTR_ACK;
                        end
                    end
                    PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        bit_cnt <= '0;
                        if (!sda_low) begin
                            sda_low <= 1'b1;
                        end else begin
                            sda_low <= 1'b0;
                            state   <= WDATA;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bank[ptr] <= rx_byte;
                            ptr       <= ptr + 3'd1;
                            wrote     <= 1'b1;
                            state     <= WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_low  <= 1'b0;
                                ptr      <= ptr + 3'd1;
                                sent     <= 1'b1;
                                ack_seen <= 1'b0;
                                state    <= RDATA_ACK;
                            end else begin
                                sda_low <= ~shreg[7];
                                shreg   <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_f) begin
                                nack_end <= 1'b1;
                                state    <= WAIT_STOP;
                            end else begin
                                ack_seen <= 1'b1;
                                shreg    <= bank[ptr];
                            end
                        end else if (scl_fall && ack_seen) begin
                            sda_low  <= ~shreg[7];
                            shreg    <= {shreg[6:0], 1'b0};
                            bit_cnt  <= '0;
                            ack_seen <= 1'b0;
                            state    <= RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Reset gates the driver directly so sda lets go without waiting for a clock.
    assign sda  = (sda_low && !reset) ? 1'b0 : 1'bz;
    assign intr = (wr_done | rd_done) & irq_en;

    logic unused_wb_bits;
    assign unused_wb_bits = &{1'b0, wb.wb_adr_i[31:6], wb.wb_adr_i[1:0],
                              wb.wb_dat_i[31:8], wb.wb_sel_i[3:1]};

endmodule

// File: doc/wb_i2c_target.md
# wb_i2c_target

- I2C target (slave) peripheral on the Wishbone bus.
- The bus's I2C controller (`wb_i2c`) drives transactions; this block answers them.
- It gives an external I2C master an 8-byte shared register bank, which the LM32 can also read and write over Wishbone.
- It maps as a conbus slave and raises a level interrupt when an I2C transfer completes.

## Interface
- `I2C_ADDR`, 7'h42, 7-bit target address this block answers.
- `clk_freq`, 50000000, system clock in Hz; documentation only, no logic depends on it. Requires `clk_freq` ≥ 20 × SCL rate.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wb_adr_i`  in  32  byte address; only `[5:2]` are decoded.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data.
- `wb_sel_i`  in  4  byte select; only `sel[0]` gates writes.
- `wb_stb_i`, `wb_cyc_i`, `wb_we_i`  in  1  Wishbone strobe, cycle and write-enable.
- `wb_ack_o`  out  1  one-cycle acknowledge.
- `scl`  in  1  I2C clock; the block never stretches it.
- `sda`  inout  1  I2C data; open-drain, driven only to 0, otherwise `1'bz`.
- `intr`  out  1  `(status[2:1] != 0) & ctrl[1]`.

## Operation
- Wishbone register map, by `adr[5:2]`:
  - 0–7: `bank[n]` in `[7:0]`; upper bits read 0.
  - 8: `STATUS`:
    - b0 `addressed` (read-only)
    - b1 `wr_done`
    - b2 `rd_done`
    - b3 `nack_end`
    - b1–b3 are sticky, write-1-to-clear.
  - 9: `CTRL`: b0 `enable`, b1 `irq_en`.
  - Others: read 0, writes ignored.
- Input path: `scl`/`sda` pass through 2-flop synchronizers. Edges and conditions are detected on the synchronized values:
  - START: `sda` falls while `scl` is high.
  - STOP: `sda` rises while `scl` is high.
- FSM states: `IDLE`, `ADDR`, `ADDR_ACK`, `PTR`, `PTR_ACK`, `WDATA`, `WDATA_ACK`, `RDATA`, `RDATA_ACK`, `WAIT_STOP`.
- `IDLE`: START with `enable`=1 goes to `ADDR`. The bit counter clears to 0.
- `ADDR`: shift 8 bits MSB first, sampled on `scl` rising edges.
  - Address matches `I2C_ADDR`: go to `ADDR_ACK` and set `addressed`=1.
  - No match: go to `WAIT_STOP`.
- `ADDR_ACK`: pull `sda` low for the 9th clock.
  - R/W=0: next state is `PTR`.
  - R/W=1: load the shift register with `bank[ptr]` and go to `RDATA`.
- `PTR`: the received byte sets `ptr` = byte[2:0]. ACK, then go to `WDATA`.
- `WDATA`: each received byte writes `bank[ptr]` on the 8th rising edge, then `ptr` ← `ptr`+1 (wraps 7→0). Always ACKed.
- `RDATA`: drive bits MSB first. After the 8th bit, `ptr` increments and the block samples the master's ACK in `RDATA_ACK`.
  - ACK (0): load the next byte and stay in `RDATA`.
  - NACK (1): set `nack_end` and go to `WAIT_STOP`.
- STOP in any state: go to `IDLE`, clear `addressed`, release `sda`.
  - STOP ending a write that committed ≥1 data byte sets `wr_done`.
  - STOP ending a read that sent ≥1 byte sets `rd_done`.
- Repeated START in any non-`IDLE` state: go to `ADDR`; `ptr` is retained.
- `enable` cleared mid-transfer: current transfer finishes; new STARTs are ignored.

## Timing
- Reset values: `wb_dat_o`=0, `wb_ack_o`=0, `intr`=0, `sda` released (z), `ptr`=0, bank=0, `STATUS`=0, `CTRL`=0, FSM=`IDLE`.
- Wishbone:
  - `ack` is asserted the cycle after `stb&cyc&!ack` and lasts exactly 1 cycle.
  - Read data is valid with `ack`.
  - Writes commit on the ack cycle.
- I2C input latency: 2 clk cycles through the synchronizer, plus 1 cycle for edge detect.
- `sda` output updates 1 cycle after a detected `scl` falling edge (data or ACK bit). It is released on the falling edge ending the ACK/data slot.
- Collision: Wishbone write and I2C commit to the same `bank` byte in the same cycle → the I2C value wins.
- Collision: `STATUS` W1C in the same cycle as a set → set wins.
- Reset asserted mid-transaction: `sda` is released combinationally (asynchronous), with no glitch low.

## Configuration
- `I2C_TARGET_GLITCH_FILTER_EN`:
  - Defined: after the synchronizer, `scl`/`sda` each pass a filter that changes value only after 3 consecutive equal samples. This rejects spikes ≤2 clk and adds 3 cycles to input latency.
  - Undefined: synchronizer only.

## Test plan
- Write: master sends START, 0x84, 0x02, 0xA5, 0x5A, STOP → all bytes ACKed; `bank[2]`=0xA5, `bank[3]`=0x5A, `ptr`=4, `wr_done`=1, `intr`=1 with `irq_en`=1.
- Read with wrap: Wishbone loads `bank[7]`=0x11, `bank[0]`=0x22. Master sends START, 0x84, 0x07, repeated START, 0x85, reads 2 bytes (ACK, then NACK), STOP → master sees 0x11, 0x22; `rd_done`=1, `nack_end`=1.
- Wrong address: master sends START, 0x90 → 9th bit `sda` stays high (NACK); bank and `STATUS` unchanged; FSM returns to `IDLE` at STOP.
- Collision: Wishbone write of 0x33 to `bank[4]` in the same cycle as the I2C commit of 0xC3 → `bank[4]`=0xC3.
- Reset mid-read: assert `reset` while driving a 0 bit → `sda`=z immediately; all `STATUS`/`CTRL` bits read 0 after reset.
- With `I2C_TARGET_GLITCH_FILTER_EN`: a 2-cycle low pulse on `sda` while `scl` is high → no START detected, FSM stays `IDLE`.
